// File: rtl/random_delay_generator_pkg.sv
// Shared constants and helpers for the pseudo-random stall generators.
package random_delay_generator_pkg;

   localparam int          LFSR_W       = 16;
   // Feedback taps at bits 15,13,12,10: x^16+x^14+x^13+x^11+1, period 65535.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   // The all-zero state would lock the LFSR, so a zero seed becomes 1.
   function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] seed);
      return (seed == '0) ? 16'h0001 : seed;
   endfunction

endpackage

// File: rtl/random_delay_generator_if.sv
// Permission pulse towards a bus master, plus read-only debug view of the
// generator state (LFSR and gap counter, counter zero-extended to 8 bits).
interface random_delay_if;
   import random_delay_generator_pkg::*;

   logic              delay_trigger;
   logic [LFSR_W-1:0] dbg_lfsr;
   logic [7:0]        dbg_count;

   // Generator drives everything; the master only observes.
   modport master (output delay_trigger, output dbg_lfsr, output dbg_count);
   modport slave  (input  delay_trigger, input  dbg_lfsr, input  dbg_count);

endinterface

// File: rtl/random_delay_generator_lfsr16_step.sv
// Combinational next-state function of the 16-bit Fibonacci LFSR.
module lfsr16_step
   import random_delay_generator_pkg::*;
(
   input  logic [LFSR_W-1:0] lfsr,
   output logic [LFSR_W-1:0] next_lfsr
);

   logic fb;

   // Parity of the tapped bits shifts in at the bottom.
   always_comb begin
      fb        = ^(lfsr & LFSR_TAPS);
      next_lfsr = {lfsr[LFSR_W-2:0], fb};
   end

endmodule

// File: rtl/random_delay_generator.sv
// Pseudo-random stall source: one-cycle delay_trigger pulses separated by
// gaps whose length is taken from the low DELAY_BITS of a 16-bit LFSR.
// Handshake: delay_trigger is a registered permission; the master may raise
// its valid/ready only in cycles where delay_trigger is high. There is no
// back-pressure into this block.
module random_delay_generator
   import random_delay_generator_pkg::*;
#(
   parameter logic [15:0] SEED       = DEFAULT_SEED,
   parameter int          DELAY_BITS = 3,
   parameter bit          RANDOM_EN  = 1'b1
)
(
   input  logic          clk,
   input  logic          rst,
   random_delay_if.master dly
);

   localparam logic [LFSR_W-1:0] RESET_SEED = safe_seed(SEED);

   logic [LFSR_W-1:0]     lfsr;
   logic [LFSR_W-1:0]     lfsr_next;
   logic [DELAY_BITS-1:0] count;
   logic [DELAY_BITS-1:0] count_next;
   logic                  trigger;
   logic                  trigger_next;

   lfsr16_step u_step (
      .lfsr      (lfsr),
      .next_lfsr (lfsr_next)
   );

   // A zero count fires the pulse and loads the next gap from the current
   // LFSR value; otherwise the gap counts down. With random gaps disabled
   // the output is forced high while the counter keeps running unseen.
   always_comb begin
      trigger_next = 1'b0;
      count_next   = count;
      if (count == '0) begin
         trigger_next = 1'b1;
         count_next   = lfsr[DELAY_BITS-1:0];
      end else begin
         trigger_next = !RANDOM_EN;
         count_next   = count - 1'b1;
      end
   end

   // State registers; reset has priority and restarts the identical sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr    <= RESET_SEED;
         count   <= '0;
         trigger <= 1'b0;
      end else begin
         lfsr    <= lfsr_next;
         count   <= count_next;
         trigger <= trigger_next;
      end
   end

   assign dly.delay_trigger = trigger;
   assign dly.dbg_lfsr      = lfsr;
   assign dly.dbg_count     = 8'(count);

endmodule

// File: tb/tb_random_delay_generator.sv
// Bench for random_delay_generator: three instances (seed ACE1 random,
// random disabled, seed 0) share clock and reset and are compared against
// a pulse-train model built from the LFSR sequence.
module tb_random_delay_generator;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   random_delay_if if_a ();
   random_delay_if if_b ();
   random_delay_if if_c ();

   random_delay_generator #(.SEED(16'hACE1), .DELAY_BITS(3), .RANDOM_EN(1'b1)) dut_a (
      .clk (clk), .rst (rst), .dly (if_a));
   random_delay_generator #(.SEED(16'hACE1), .DELAY_BITS(3), .RANDOM_EN(1'b0)) dut_b (
      .clk (clk), .rst (rst), .dly (if_b));
   random_delay_generator #(.SEED(16'h0000), .DELAY_BITS(3), .RANDOM_EN(1'b1)) dut_c (
      .clk (clk), .rst (rst), .dly (if_c));

   // ---------------- counters / scoreboard ----------------
   int n_asserts = 0;
   int n_fails   = 0;

   logic [0:0]  exp_qa[$];
   logic [0:0]  exp_qc[$];
   logic [15:0] ma;
   logic [15:0] mc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_next(input logic [15:0] l);
      logic fb;
      fb = l[15] ^ l[13] ^ l[12] ^ l[10];
      return {l[14:0], fb};
   endfunction

   task automatic model_reset();
      ma = 16'hACE1;
      mc = 16'h0001;
      exp_qa.delete();
      exp_qc.delete();
   endtask

   // One post-reset edge: a pulse followed by D idle cycles, D from the
   // LFSR value current at the pulse edge.
   task automatic model_tick(output logic ea, output logic ec);
      if (exp_qa.size() == 0) begin
         exp_qa.push_back(1'b1);
         repeat (int'(ma[2:0])) exp_qa.push_back(1'b0);
      end
      if (exp_qc.size() == 0) begin
         exp_qc.push_back(1'b1);
         repeat (int'(mc[2:0])) exp_qc.push_back(1'b0);
      end
      ea = exp_qa.pop_front();
      ec = exp_qc.pop_front();
      ma = model_next(ma);
      mc = model_next(mc);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_trig_a"}, 32'(if_a.delay_trigger), 32'd0);
      check({tag, "_lfsr_a"}, 32'(if_a.dbg_lfsr), 32'hACE1);
      check({tag, "_cnt_a"},  32'(if_a.dbg_count), 32'd0);
      check({tag, "_trig_b"}, 32'(if_b.delay_trigger), 32'd0);
      check({tag, "_lfsr_c"}, 32'(if_c.dbg_lfsr), 32'h0001);
   endtask

   task automatic run_checked(input string tag, input int n);
      logic ea, ec;
      for (int i = 0; i < n; i++) begin
         step();
         model_tick(ea, ec);
         check({tag, "_a"}, 32'(if_a.delay_trigger), 32'(ea));
         check({tag, "_b"}, 32'(if_b.delay_trigger), 32'd1);
         check({tag, "_c"}, 32'(if_c.delay_trigger), 32'(ec));
      end
   endtask

   task automatic run_scenario1(input string tag);
      logic [0:0] dir [11];
      logic ea, ec;
      dir = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 11; i++) begin
         step();
         model_tick(ea, ec);
         check({tag, "_const"}, 32'(if_a.delay_trigger), 32'(dir[i]));
         check({tag, "_model"}, 32'(if_a.delay_trigger), 32'(ea));
         check({tag, "_c"},     32'(if_c.delay_trigger), 32'(ec));
         check({tag, "_b"},     32'(if_b.delay_trigger), 32'd1);
         if (i == 0) begin
            check({tag, "_lfsr1"}, 32'(if_a.dbg_lfsr), 32'h59C3);
            check({tag, "_cnt1"},  32'(if_a.dbg_count), 32'd1);
            check({tag, "_cnt1_c"}, 32'(if_c.dbg_count), 32'd1);
         end
         if (i == 1) check({tag, "_lfsr2"}, 32'(if_a.dbg_lfsr), 32'hB387);
         if (i == 2) check({tag, "_cnt3"},  32'(if_a.dbg_count), 32'd7);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      int k;
      int last_hi;
      int gap;
      int first_ret;
      int zero_seen;
      bit gap_seen [8];
      logic ea, ec;

      // Reset held for five cycles.
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         check_reset_state("hold_rst");
      end

      // Release: directed first pulse train.
      rst = 1'b0;
      run_scenario1("scn1");

      // Restart, then reset for one cycle in the middle of the 7-cycle gap.
      rst = 1'b1;
      step();
      check_reset_state("pre_mid");
      rst = 1'b0;
      model_reset();
      k = $urandom_range(4, 9);
      run_checked("pre_gap", k);
      check("in_gap", 32'(if_a.delay_trigger), 32'd0);
      rst = 1'b1;
      step();
      check_reset_state("mid_gap_rst");
      rst = 1'b0;
      model_reset();
      run_scenario1("replay");

      // Random run lengths interrupted by random-length resets.
      for (int r = 0; r < 12; r++) begin
         rst = 1'b1;
         repeat ($urandom_range(1, 3)) step();
         check_reset_state("rand_rst");
         rst = 1'b0;
         model_reset();
         run_checked("rand_run", $urandom_range(1, 60));
      end

      // Long run: gap range/coverage, LFSR period, no zero state.
      rst = 1'b1;
      step();
      step();
      check_reset_state("long_rst");
      rst = 1'b0;
      model_reset();
      last_hi   = -1;
      first_ret = 0;
      zero_seen = 0;
      foreach (gap_seen[g]) gap_seen[g] = 1'b0;
      for (int n = 1; n <= 70000; n++) begin
         step();
         model_tick(ea, ec);
         check("long_a", 32'(if_a.delay_trigger), 32'(ea));
         check("long_b", 32'(if_b.delay_trigger), 32'd1);
         check("long_c", 32'(if_c.delay_trigger), 32'(ec));
         if (if_a.delay_trigger === 1'b1) begin
            if (last_hi >= 0) begin
               gap = n - last_hi - 1;
               check("gap_range", 32'(gap <= 7), 32'd1);
               if (gap >= 0 && gap <= 7) gap_seen[gap] = 1'b1;
            end
            last_hi = n;
         end
         if (first_ret == 0 && if_a.dbg_lfsr === 16'hACE1) first_ret = n;
         if (if_c.dbg_lfsr === 16'h0000) zero_seen++;
      end
      for (int g = 0; g < 8; g++) check($sformatf("gap_seen_%0d", g), 32'(gap_seen[g]), 32'd1);
      check("lfsr_period", 32'(first_ret), 32'd65535);
      check("lfsr_c_never_zero", 32'(zero_seen), 32'd0);

      // ---------------- final report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
